// File: rtl/multicycle_controller.sv
// Multicycle controller: Moore FSM sequencing fetch/decode/execute for a small
// ARM-like datapath. Outputs are a function of the current state and the
// instruction register contents.
module multicycle_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_out,
    output logic        illegal
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    state_e state_q, state_d;
    logic   cond_ok_q, cond_ok_d;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, u_bit, link;
    assign cond  = INSTRUCTION_OUT[31:28];
    assign op    = INSTRUCTION_OUT[27:26];
    assign i_bit = INSTRUCTION_OUT[25];
    assign cmd   = INSTRUCTION_OUT[24:21];
    assign s_bit = INSTRUCTION_OUT[20];
    assign u_bit = INSTRUCTION_OUT[23];
    assign link  = INSTRUCTION_OUT[24];

    // Register numbers and immediates are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTRUCTION_OUT[19:12], INSTRUCTION_OUT[4:0]};

    // Condition check against {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v, cond_pass;
    assign {flag_n, flag_z, flag_c, flag_v} = FLAGS;

    always_comb begin
        unique case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Data-processing command decode
    logic [2:0] exec_aluop;
    logic       cmd_legal, is_cmp;
    always_comb begin
        exec_aluop = 3'b100;
        cmd_legal  = 1'b1;
        is_cmp     = 1'b0;
        unique case (cmd)
            4'b0000: exec_aluop = 3'b000;
            4'b0010: exec_aluop = 3'b010;
            4'b0100: exec_aluop = 3'b100;
            4'b1100: exec_aluop = 3'b110;
            4'b1010: begin
                exec_aluop = 3'b010;
                is_cmp     = 1'b1;
            end
            4'b1101: exec_aluop = 3'b111;
            default: cmd_legal = 1'b0;
        endcase
    end

    // cond_ok is captured while decoding and held for the rest of the instruction
    assign cond_ok_d = (state_q == StDecode) ? cond_pass : cond_ok_q;

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StFetch;
            cond_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (!cond_pass || op == 2'b11) begin
                    state_d = StFetch;
                end else if (op == 2'b01) begin
                    state_d = StMemAdr;
                end else if (op == 2'b10) begin
                    state_d = StBranch;
                end else begin
                    state_d = i_bit ? StExecI : StExecR;
                end
            end
            StMemAdr:   state_d = s_bit ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecR, StExecI: state_d = (!cmd_legal || is_cmp) ? StFetch : StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Output logic; commits after decode are additionally qualified by cond_ok
    always_comb begin
        logic commit_ok;
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        illegal    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUop      = 3'b100;
        ShiftType  = 3'b111;
        RegSrc     = (state_q == StFetch) ? 2'b00 : {op == 2'b01, op == 2'b10};
        commit_ok  = cond_ok_q;
        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                commit_ok = 1'b1;
            end
            StDecode: begin
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                illegal   = (op == 2'b11);
                commit_ok = 1'b1;
            end
            StMemAdr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUop   = u_bit ? 3'b100 : 3'b010;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                AdrSrc    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            StExecR, StExecI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = (state_q == StExecI) ? 2'b01 : 2'b00;
                if (state_q == StExecR && INSTRUCTION_OUT[11:7] != 5'd0) begin
                    ShiftType = {1'b0, INSTRUCTION_OUT[6:5]};
                end
                if (cmd_legal) begin
                    ALUop      = exec_aluop;
                    FlagUpdate = is_cmp | s_bit;
                end else begin
                    illegal = 1'b1;
                end
            end
            StAluWb: RegWrite = 1'b1;
            StBranch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                if (link) begin
                    RegWrite = 1'b1;
                    A3Src    = 1'b1;
                    WD3Src   = 1'b1;
                end
            end
            default: ;
        endcase
        if (!commit_ok) begin
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            PCWrite    = 1'b0;
            FlagUpdate = 1'b0;
        end
        if (!reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            FlagUpdate = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state_out = state_q;

endmodule
